boot_load_ctrl: RTL

Sequences the UART program loader against the CPU and arbitrates the single memory write port between them. In run mode the CPU owns the instruction and data memory write ports. On a load request the block stalls the CPU, clears the UART receiver and routes received words into IMEM or DMEM by address region. When the UART reports completion it issues a CPU restart pulse. It sits between the Uart receiver, the CPU core and the memory wrappers at top level.

---
 rtl/boot_pkg.sv | 25 ++
 rtl/btn_sync_edge.sv | 38 +++
 rtl/boot_load_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader controller: FSM state encoding,
// memory region sizes and small address helpers.
package boot_pkg;

    localparam int unsigned BOOT_DATA_W     = 32;
    localparam int unsigned BOOT_ADDR_W     = 32;
    localparam int unsigned BOOT_CNT_W      = 16;
    localparam int unsigned BOOT_RST_CYC    = 16;
    localparam int unsigned BOOT_IMEM_BYTES = 32'h0001_0000;
    localparam int unsigned BOOT_DMEM_BYTES = 32'h0001_0000;

    // Encoding is visible on state_led, so the values are fixed.
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_LOAD   = 2'd2,
        S_FINISH = 2'd3
    } state_e;

    // True when the byte offset within a word is zero.
    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return byte_off == 2'b00;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus a registered
// rising-edge detector. rise_o is a one-cycle pulse, 3 cycles after the
// button goes high.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   btn_i  - raw asynchronous button level
//   rise_o - one-cycle pulse on a synchronized rising edge
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // Synchronizer chain and edge register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot load controller: stalls the CPU on a load request, clears the UART
// receiver, routes received words into IMEM or DMEM by address region and
// restarts the CPU when the UART reports completion. In RUN/DRAIN the CPU
// owns the memory write port (combinational pass-through); in LOAD/FINISH
// the loader drives it from registers.
// Ports:
//   clk, reset                          - clock, async active-low reset
//   load_btn                            - raw load-request button
//   uart_valid/addr/data/done           - word stream from the UART loader
//   uart_clear                          - one-cycle UART reset pulse
//   cpu_busy/we/addr/wdata              - CPU store status and write port
//   cpu_hold, cpu_rst                   - CPU stall and restart
//   imem_we, dmem_we, mem_addr, mem_wdata - shared memory write port
//   word_cnt, load_err, state_led       - load status
module boot_load_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned DATA_W     = BOOT_DATA_W,
    parameter int unsigned ADDR_W     = BOOT_ADDR_W,
    parameter int unsigned IMEM_BYTES = BOOT_IMEM_BYTES,
    parameter int unsigned DMEM_BYTES = BOOT_DMEM_BYTES,
    parameter int unsigned RST_CYC    = BOOT_RST_CYC,
    parameter int unsigned CNT_W      = BOOT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_btn,
    input  logic              uart_valid,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_data,
    input  logic              uart_done,
    output logic              uart_clear,
    input  logic              cpu_busy,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              load_err,
    output logic [1:0]        state_led
);

    localparam int unsigned       RC_W      = $clog2(RST_CYC) + 1;
    localparam logic [ADDR_W-1:0] IMEM_BASE = ADDR_W'(IMEM_BYTES);
    localparam logic [ADDR_W:0]   MEM_END   = (ADDR_W+1)'(IMEM_BYTES) + (ADDR_W+1)'(DMEM_BYTES);

    logic load_rise;

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  word_cnt_q,   word_cnt_d;
    logic              load_err_q,   load_err_d;
    logic              uart_clear_q, uart_clear_d;
    logic              ld_imem_we_q, ld_imem_we_d;
    logic              ld_dmem_we_q, ld_dmem_we_d;
    logic [ADDR_W-1:0] ld_idx_q,     ld_idx_d;
    logic [DATA_W-1:0] ld_wdata_q,   ld_wdata_d;
    logic [RC_W-1:0]   rst_cnt_q,    rst_cnt_d;
    logic              cpu_hold_q;
    logic              cpu_rst_q;

    logic uart_bad;
    logic uart_in_imem;

    btn_sync_edge u_load_btn (
        .clk    (clk),
        .rst_n  (reset),
        .btn_i  (load_btn),
        .rise_o (load_rise)
    );

    // Region decode of the incoming UART word
    assign uart_bad     = !is_word_aligned(uart_addr[1:0]) || ({1'b0, uart_addr} >= MEM_END);
    assign uart_in_imem = uart_addr < IMEM_BASE;

    // State and loader registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_RUN;
            word_cnt_q   <= '0;
            load_err_q   <= 1'b0;
            uart_clear_q <= 1'b0;
            ld_imem_we_q <= 1'b0;
            ld_dmem_we_q <= 1'b0;
            ld_idx_q     <= '0;
            ld_wdata_q   <= '0;
            rst_cnt_q    <= '0;
            cpu_hold_q   <= 1'b0;
            cpu_rst_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            load_err_q   <= load_err_d;
            uart_clear_q <= uart_clear_d;
            ld_imem_we_q <= ld_imem_we_d;
            ld_dmem_we_q <= ld_dmem_we_d;
            ld_idx_q     <= ld_idx_d;
            ld_wdata_q   <= ld_wdata_d;
            rst_cnt_q    <= rst_cnt_d;
            cpu_hold_q   <= (state_d != S_RUN);
            cpu_rst_q    <= (state_d == S_FINISH);
        end
    end

    // Next-state and loader write capture
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        load_err_d   = load_err_q;
        uart_clear_d = 1'b0;
        ld_imem_we_d = 1'b0;
        ld_dmem_we_d = 1'b0;
        ld_idx_d     = ld_idx_q;
        ld_wdata_d   = ld_wdata_q;
        rst_cnt_d    = '0;

        case (state_q)
            S_RUN: begin
                if (load_rise) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!cpu_busy) begin
                    uart_clear_d = 1'b1;
                    word_cnt_d   = '0;
                    load_err_d   = 1'b0;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                // A second button press aborts; any word that cycle is dropped.
                if (load_rise) begin
                    load_err_d = 1'b1;
                    state_d    = S_FINISH;
                end else begin
                    if (uart_valid) begin
                        if (uart_bad) begin
                            load_err_d = 1'b1;
                        end else begin
                            ld_imem_we_d = uart_in_imem;
                            ld_dmem_we_d = !uart_in_imem;
                            ld_idx_d     = uart_in_imem ? (uart_addr >> 2)
                                                        : ((uart_addr - IMEM_BASE) >> 2);
                            ld_wdata_d   = uart_data;
                            if (word_cnt_q != '1) begin
                                word_cnt_d = word_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    // The registered write lands in the first FINISH cycle.
                    if (uart_done) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Memory port mux: CPU pass-through in RUN/DRAIN, loader registers otherwise.
    // Address/data are zeroed when the CPU is not writing so the port idles at 0.
    always_comb begin
        imem_we   = 1'b0;
        dmem_we   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == S_RUN || state_q == S_DRAIN) begin
            if (cpu_we && reset) begin
                dmem_we   = 1'b1;
                mem_addr  = (cpu_addr - IMEM_BASE) >> 2;
                mem_wdata = cpu_wdata;
            end
        end else begin
            imem_we   = ld_imem_we_q;
            dmem_we   = ld_dmem_we_q;
            mem_addr  = ld_idx_q;
            mem_wdata = ld_wdata_q;
        end
    end

    assign uart_clear = uart_clear_q;
    assign cpu_hold   = cpu_hold_q;
    assign cpu_rst    = cpu_rst_q;
    assign word_cnt   = word_cnt_q;
    assign load_err   = load_err_q;
    assign state_led  = state_q;

endmodule
